sprite_draw_engine: RTL and testbench

Responder side of the character/background draw handshake. Accepts single-cycle `drawBG`/`drawChar` requests with a top-left coordinate from the movement controller. Rasterises a SPRITE_W×SPRITE_H box into the 320×240 VGA adapter write port, taking pixels from a background ROM (screen-addressed) or a character ROM (sprite-addressed). Signals completion with single-cycle `doneBG`/`doneChar` pulses.

---
 rtl/sprite_draw_engine_pkg.sv | 21 ++
 rtl/sprite_draw_engine_if.sv | 16 +
 rtl/sprite_pixel_counter.sv | 41 ++++
 rtl/sprite_draw_engine.sv | 167 ++++++++++++++++
 tb/tb_sprite_draw_engine.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants and types for the sprite draw engine.
// Covers the screen geometry, the coordinate widths and the job/state encodings.
package sprite_draw_engine_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] TRANSPARENT = 3'b000;

  typedef enum logic { JOB_BG = 1'b0, JOB_CHAR = 1'b1 } job_t;

  typedef enum logic [1:0] { IDLE, ISSUE, PLOT, DONE } state_t;

  // Sums are one bit wider than the screen coordinates so they cannot wrap
  function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
    return (x < (X_W+1)'(SCREEN_W)) && (y < (Y_W+1)'(SCREEN_H));
  endfunction

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Draw request/completion handshake between the movement controller and the engine.
interface sprite_draw_engine_if;
  import sprite_draw_engine_pkg::*;

  logic           drawBG;
  logic           drawChar;
  logic [X_W-1:0] xIn;
  logic [Y_W-1:0] yIn;
  logic           doneBG;
  logic           doneChar;
  logic           busy;

  modport master (output drawBG, drawChar, xIn, yIn, input doneBG, doneChar, busy);
  modport slave  (input drawBG, drawChar, xIn, yIn, output doneBG, doneChar, busy);

endinterface

// File: rtl/sprite_pixel_counter.sv
// Raster-order col/row walker over one sprite box.
// The last output flags the bottom-right pixel.
module sprite_pixel_counter
  import sprite_draw_engine_pkg::*;
#(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == CW'(SPRITE_W - 1));
  assign row_end = (row == RW'(SPRITE_H - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_engine.sv
// Rasterises a SPRITE_W x SPRITE_H box from the background or character ROM
// into the VGA adapter, two cycles per pixel (address issue, then plot).
module sprite_draw_engine
  import sprite_draw_engine_pkg::*;
#(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int COLOUR_W = sprite_draw_engine_pkg::COLOUR_W,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = sprite_draw_engine_pkg::TRANSPARENT,
  localparam int CA_W = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1,
  localparam int CW   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int RW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  sprite_draw_engine_if.slave  host,
  output logic [16:0]          bgAddr,
  input  logic [COLOUR_W-1:0]  bgData,
  output logic [CA_W-1:0]      charAddr,
  input  logic [COLOUR_W-1:0]  charData,
  output logic [X_W-1:0]       vgaX,
  output logic [Y_W-1:0]       vgaY,
  output logic [COLOUR_W-1:0]  colour,
  output logic                 plot
);

  state_t         state_reg;
  job_t           job_reg;
  logic [X_W-1:0] base_x_reg;
  logic [Y_W-1:0] base_y_reg;
  logic           done_bg_reg;
  logic           done_char_reg;
  logic           busy_reg;

  logic [1:0]     req;
  logic [1:0]     pend_eff;
  logic [1:0]     clr;
  logic [X_W-1:0] x_eff [2];
  logic [Y_W-1:0] y_eff [2];

  logic           start;
  job_t           start_job;
  logic [X_W-1:0] start_x;
  logic [Y_W-1:0] start_y;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           last;

  // Slot 0 holds the background request, slot 1 the character request
  assign req = {host.drawChar, host.drawBG};

  // One-deep pending slot per job type; a same-cycle request is visible immediately
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic           pend_reg;
    logic [X_W-1:0] x_reg;
    logic [Y_W-1:0] y_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        pend_reg <= 1'b0;
        x_reg    <= '0;
        y_reg    <= '0;
      end else begin
        if (clr[gi])
          pend_reg <= 1'b0;
        else if (req[gi])
          pend_reg <= 1'b1;
        if (req[gi]) begin
          x_reg <= host.xIn;
          y_reg <= host.yIn;
        end
      end
    end

    assign pend_eff[gi] = pend_reg | req[gi];
    assign x_eff[gi]    = req[gi] ? host.xIn : x_reg;
    assign y_eff[gi]    = req[gi] ? host.yIn : y_reg;
  end

  assign start     = (state_reg == IDLE) && (|pend_eff);
  assign start_job = pend_eff[0] ? JOB_BG : JOB_CHAR;
  assign start_x   = pend_eff[0] ? x_eff[0] : x_eff[1];
  assign start_y   = pend_eff[0] ? y_eff[0] : y_eff[1];
  assign clr[0]    = start && pend_eff[0];
  assign clr[1]    = start && !pend_eff[0];

  sprite_pixel_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (start),
    .advance (state_reg == PLOT),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      job_reg       <= JOB_BG;
      base_x_reg    <= '0;
      base_y_reg    <= '0;
      done_bg_reg   <= 1'b0;
      done_char_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      done_bg_reg   <= 1'b0;
      done_char_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            job_reg    <= start_job;
            base_x_reg <= start_x;
            base_y_reg <= start_y;
            busy_reg   <= 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: state_reg <= PLOT;
        PLOT: begin
          if (last) begin
            done_bg_reg   <= (job_reg == JOB_BG);
            done_char_reg <= (job_reg == JOB_CHAR);
            state_reg     <= DONE;
          end else begin
            state_reg <= ISSUE;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign host.doneBG   = done_bg_reg;
  assign host.doneChar = done_char_reg;
  assign host.busy     = busy_reg;

  // Pixel coordinates; the extra top bit keeps off-screen pixels from aliasing
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  logic [16:0]  y_ext;
  logic         pix_on;
  logic         in_plot;

  assign x_sum  = {1'b0, base_x_reg} + (X_W+1)'(col);
  assign y_sum  = {1'b0, base_y_reg} + (Y_W+1)'(row);
  assign y_ext  = 17'(y_sum);
  assign pix_on = on_screen(x_sum, y_sum);

  assign bgAddr   = (y_ext << 8) + (y_ext << 6) + 17'(x_sum);
  assign charAddr = CA_W'(int'(row) * SPRITE_W + int'(col));

  assign in_plot = (state_reg == PLOT);
  assign vgaX    = x_sum[X_W-1:0];
  assign vgaY    = y_sum[Y_W-1:0];
  assign colour  = in_plot ? ((job_reg == JOB_CHAR) ? charData : bgData) : '0;
  assign plot    = in_plot && pix_on && !((job_reg == JOB_CHAR) && (charData == TRANSPARENT));

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Scoreboard bench: a raster model pushes expected plots and done pulses,
// a negedge monitor pops and compares whatever the engine emits.
module tb_sprite_draw_engine;
  import sprite_draw_engine_pkg::*;

  localparam int SW = 8;
  localparam int SH = 8;
  localparam int N  = SW * SH;

  logic        clock = 1'b0;
  logic        reset;
  logic [16:0] bgAddr;
  logic [2:0]  bgData;
  logic [5:0]  charAddr;
  logic [2:0]  charData;
  logic [8:0]  vgaX;
  logic [7:0]  vgaY;
  logic [2:0]  colour;
  logic        plot;

  always #5 clock = ~clock;

  sprite_draw_engine_if bus ();

  sprite_draw_engine #(.SPRITE_W(SW), .SPRITE_H(SH)) dut (
    .clock    (clock),
    .reset    (reset),
    .host     (bus),
    .bgAddr   (bgAddr),
    .bgData   (bgData),
    .charAddr (charAddr),
    .charData (charData),
    .vgaX     (vgaX),
    .vgaY     (vgaY),
    .colour   (colour),
    .plot     (plot)
  );

  // ROM models with one cycle of read latency
  logic [2:0] char_rom [N];

  function automatic logic [2:0] bg_pixel(input int addr);
    return 3'(addr ^ (addr >> 5) ^ (addr >> 11));
  endfunction

  always @(posedge clock) begin
    bgData   <= bg_pixel(int'(bgAddr));
    charData <= char_rom[charAddr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int x; int y; int c; int t; } plot_t;
  typedef struct { bit is_char; int t; } done_t;

  plot_t plot_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    passed = 0;

  function automatic void check(input bit ok, input string name, input string got, input string exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %s, expected %s", name, got, exp);
  endfunction

  // Reference model: walk the box in raster order, pixel k plotted at t+2+2k
  function automatic void push_job(input bit is_char, input int x, input int y, input int t);
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        int px = x + c;
        int py = y + r;
        int k  = r * SW + c;
        int col;
        if (px < SCREEN_W && py < SCREEN_H) begin
          col = is_char ? int'(char_rom[k]) : int'(bg_pixel(py * SCREEN_W + px));
          if (!is_char || col != 0) plot_q.push_back('{px, py, col, t + 2 + 2 * k});
        end
      end
    end
    done_q.push_back('{is_char, t + 1 + 2 * N});
  endfunction

  function automatic void take_done(input bit is_char);
    done_t d;
    if (done_q.size() == 0) begin
      check(1'b0, "unexpected_done", $sformatf("char=%0d @%0d", is_char, cyc), "none");
    end else begin
      d = done_q.pop_front();
      check(d.is_char == is_char && d.t == cyc, "done",
            $sformatf("char=%0d @%0d", is_char, cyc), $sformatf("char=%0d @%0d", d.is_char, d.t));
    end
  endfunction

  always @(negedge clock) begin
    plot_t p;
    if (!reset) begin
      if (plot) begin
        if (plot_q.size() == 0) begin
          check(1'b0, "unexpected_plot", $sformatf("(%0d,%0d) @%0d", vgaX, vgaY, cyc), "none");
        end else begin
          p = plot_q.pop_front();
          check(int'(vgaX) == p.x && int'(vgaY) == p.y && int'(colour) == p.c && cyc == p.t, "plot",
                $sformatf("(%0d,%0d) c%0d @%0d", vgaX, vgaY, colour, cyc),
                $sformatf("(%0d,%0d) c%0d @%0d", p.x, p.y, p.c, p.t));
        end
      end
      if (bus.doneBG) take_done(1'b0);
      if (bus.doneChar) take_done(1'b1);
    end
  end

  task automatic issue(input bit bg, input bit ch, input int x, input int y, output int t);
    @(negedge clock); #1;
    bus.drawBG   = bg;
    bus.drawChar = ch;
    bus.xIn      = 9'(x);
    bus.yIn      = 8'(y);
    t = cyc;
    $display("req bg=%0d char=%0d at (%0d,%0d) cycle %0d", bg, ch, x, y, t);
    @(negedge clock); #1;
    bus.drawBG   = 1'b0;
    bus.drawChar = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((plot_q.size() != 0 || done_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(n < budget, "drain", $sformatf("%0d plots/%0d dones left", plot_q.size(), done_q.size()), "empty");
    repeat (2) @(negedge clock);
  endtask

  task automatic rand_char_rom();
    for (int k = 0; k < N; k++)
      char_rom[k] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
  endtask

  int t0;
  int t1;
  int rx;
  int ry;
  bit rc;

  initial begin
    reset        = 1'b1;
    bus.drawBG   = 1'b0;
    bus.drawChar = 1'b0;
    bus.xIn      = '0;
    bus.yIn      = '0;
    for (int k = 0; k < N; k++) char_rom[k] = 3'd0;
    repeat (3) @(negedge clock);

    check(plot == 1'b0 && bus.busy == 1'b0, "reset_ctl", $sformatf("plot=%0d busy=%0d", plot, bus.busy), "0/0");
    check(bus.doneBG == 1'b0 && bus.doneChar == 1'b0, "reset_done",
          $sformatf("%0d/%0d", bus.doneBG, bus.doneChar), "0/0");
    check(vgaX == 9'd0 && vgaY == 8'd0 && colour == 3'd0, "reset_vga",
          $sformatf("(%0d,%0d) c%0d", vgaX, vgaY, colour), "(0,0) c0");
    check(bgAddr == 17'd0 && charAddr == 6'd0, "reset_addr", $sformatf("%0d/%0d", bgAddr, charAddr), "0/0");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Background box fully on screen
    issue(1'b1, 1'b0, 1, 16, t0);
    push_job(1'b0, 1, 16, t0);
    wait_until(t0 + 130);
    check(bus.busy == 1'b0, "busy_after_bg", $sformatf("%0d", bus.busy), "0");
    wait_drain(400);

    // Character with a transparent first row
    for (int k = 0; k < N; k++) char_rom[k] = (k < SW) ? 3'd0 : 3'b101;
    issue(1'b0, 1'b1, 100, 50, t0);
    push_job(1'b1, 100, 50, t0);
    wait_drain(400);

    // Simultaneous requests: background first, character from the next idle cycle
    rand_char_rom();
    issue(1'b1, 1'b1, 10, 10, t0);
    push_job(1'b0, 10, 10, t0);
    push_job(1'b1, 10, 10, t0 + 130);
    wait_drain(600);

    // Box hanging off the bottom-right corner
    issue(1'b1, 1'b0, 316, 236, t0);
    push_job(1'b0, 316, 236, t0);
    wait_drain(400);

    // Character request while the background job is at pixel 30
    rand_char_rom();
    issue(1'b1, 1'b0, 50, 60, t0);
    push_job(1'b0, 50, 60, t0);
    wait_until(t0 + 62);
    issue(1'b0, 1'b1, 20, 20, t1);
    push_job(1'b1, 20, 20, t0 + 130);
    wait_drain(600);

    // Reset during pixel 10 abandons the job
    issue(1'b1, 1'b0, 200, 100, t0);
    push_job(1'b0, 200, 100, t0);
    wait_until(t0 + 22);
    #1;
    reset = 1'b1;
    plot_q.delete();
    done_q.delete();
    @(negedge clock);
    check(plot == 1'b0 && bus.busy == 1'b0 && bus.doneBG == 1'b0, "reset_midjob",
          $sformatf("plot=%0d busy=%0d done=%0d", plot, bus.busy, bus.doneBG), "0/0/0");
    @(negedge clock); #1;
    reset = 1'b0;
    issue(1'b1, 1'b0, 33, 44, t0);
    push_job(1'b0, 33, 44, t0);
    wait_drain(400);

    // Randomised jobs, some near the right/bottom edges
    for (int i = 0; i < 6; i++) begin
      rc = 1'($urandom_range(0, 1));
      rx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(310, 319)) : int'($urandom_range(0, 319));
      ry = ($urandom_range(0, 2) == 0) ? int'($urandom_range(230, 239)) : int'($urandom_range(0, 239));
      rand_char_rom();
      issue(!rc, rc, rx, ry, t0);
      push_job(rc, rx, ry, t0);
      wait_drain(400);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
